// File: rtl/word_seq_detector_param.sv
// word_seq_detector_param: detects a run-time programmable word of 1..MAX_LEN
// characters in a qualified letter stream. Overlapping matches, optional
// case-insensitive compare and a saturating hit counter. HIT is a registered
// one-cycle pulse in the cycle after the final letter is sampled.
module word_seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CW      = 7,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CW-1:0]              letter,
    input  logic                       letter_valid,
    input  logic                       cfg_we,
    input  logic [$clog2(MAX_LEN)-1:0] cfg_addr,
    input  logic [CW-1:0]              cfg_char,
    input  logic                       cfg_len_we,
    input  logic [LEN_W-1:0]           cfg_len,
    input  logic                       case_fold,
    output logic                       HIT,
    output logic [CNT_W-1:0]           hit_count
);

    localparam int AW = $clog2(MAX_LEN);
    localparam logic [LEN_W-1:0] LenMax  = LEN_W'(MAX_LEN);
    // Stored for any requested length above MAX_LEN; such a length never matches.
    localparam logic [LEN_W-1:0] LenOver = LEN_W'(MAX_LEN + 1);

    logic [CW-1:0]    r_pattern [MAX_LEN];
    logic [CW-1:0]    r_hist    [MAX_LEN];
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_fill;
    logic             r_hit;
    logic [CNT_W-1:0] r_count;

    logic [CW-1:0]    w_cand [MAX_LEN];
    logic             w_flush;
    logic             w_addr_ok;
    logic             w_len_ok;
    logic             w_fill_ok;
    logic             w_chars_ok;
    logic             w_hit_d;

    // Lower-case ASCII letters fold onto upper case when enabled.
    function automatic logic [CW-1:0] fold_char(input logic [CW-1:0] c, input logic en);
        if (en && (c >= CW'(8'h61)) && (c <= CW'(8'h7A))) begin
            return c - CW'(8'h20);
        end
        return c;
    endfunction

    assign w_flush   = cfg_we | cfg_len_we;
    // Widened by one bit so the range test stays meaningful when MAX_LEN is a power of two.
    assign w_addr_ok = ({1'b0, cfg_addr} < (AW + 1)'(MAX_LEN));
    assign w_len_ok  = (r_len != '0) && (r_len <= LenMax);
    assign w_fill_ok = (({1'b0, r_fill} + (LEN_W + 1)'(1)) >= {1'b0, r_len});

    // Candidate window: the incoming letter followed by the stored history.
    always_comb begin
        w_cand[0] = letter;
        for (int i = 1; i < MAX_LEN; i++) begin
            w_cand[i] = r_hist[i-1];
        end
    end

    // Compare the newest len characters against the pattern, last character first.
    always_comb begin
        w_chars_ok = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < r_len) begin
                if (fold_char(w_cand[i], case_fold) !=
                    fold_char(r_pattern[AW'(r_len - LEN_W'(i) - LEN_W'(1))], case_fold)) begin
                    w_chars_ok = 1'b0;
                end
            end
        end
    end

    // A config write in the same cycle suppresses any match.
    assign w_hit_d = letter_valid & w_len_ok & w_fill_ok & w_chars_ok & ~w_flush;

    // Pattern slots and length register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_pattern[i] <= '0;
            end
            r_len <= '0;
        end else begin
            if (cfg_we && w_addr_ok) begin
                r_pattern[cfg_addr] <= cfg_char;
            end
            if (cfg_len_we) begin
                r_len <= (cfg_len > LenOver) ? LenOver : cfg_len;
            end
        end
    end

    // Letter history shifts on accepted letters; fill tracks how much of it is fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_hist[i] <= '0;
            end
            r_fill <= '0;
        end else begin
            if (letter_valid) begin
                r_hist[0] <= letter;
                for (int i = 1; i < MAX_LEN; i++) begin
                    r_hist[i] <= r_hist[i-1];
                end
            end
            if (w_flush) begin
                r_fill <= '0;
            end else if (letter_valid && (r_fill < LenMax)) begin
                r_fill <= r_fill + LEN_W'(1);
            end
        end
    end

    // Registered hit pulse and saturating hit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit   <= 1'b0;
            r_count <= '0;
        end else begin
            r_hit <= w_hit_d;
            if (w_hit_d && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign HIT       = r_hit;
    assign hit_count = r_count;

endmodule

// File: tb/tb_word_seq_detector_param.sv
// Scoreboard bench for word_seq_detector_param: the driver pushes the expected
// (cycle, count) of every hit; the monitor pops on each HIT pulse and compares.
module tb_word_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int CW      = 7;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = 6;

    logic             clk;
    logic             rst;
    logic [CW-1:0]    letter;
    logic             letter_valid;
    logic             cfg_we;
    logic [2:0]       cfg_addr;
    logic [CW-1:0]    cfg_char;
    logic             cfg_len_we;
    logic [LEN_W-1:0] cfg_len;
    logic             case_fold;
    logic             HIT;
    logic [CNT_W-1:0] hit_count;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   model_cnt = 0;

    word_seq_detector_param #(
        .MAX_LEN(MAX_LEN),
        .CW     (CW),
        .CNT_W  (CNT_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .letter      (letter),
        .letter_valid(letter_valid),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_char    (cfg_char),
        .cfg_len_we  (cfg_len_we),
        .cfg_len     (cfg_len),
        .case_fold   (case_fold),
        .HIT         (HIT),
        .hit_count   (hit_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every HIT pulse must correspond to a queued expectation.
    always @(negedge clk) begin
        if (HIT !== 1'b0) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_hit: HIT=%b at cycle %0d, no hit expected", HIT, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL hit_cycle: got cycle %0d, expected cycle %0d", cyc, e.cyc);
                end
                checks++;
                if (int'(hit_count) != e.cnt) begin
                    errors++;
                    $display("FAIL hit_count: got %0d, expected %0d (cycle %0d)",
                             hit_count, e.cnt, cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [CW-1:0] c, input logic v, input bit exp_hit);
        letter       = c;
        letter_valid = v;
        if (exp_hit) begin
            model_cnt = (model_cnt == 3) ? 3 : model_cnt + 1;
            q.push_back('{cyc + 1, model_cnt});
        end
        tick();
        letter       = '0;
        letter_valid = 1'b0;
    endtask

    // hits holds '1' at each letter after which a HIT is expected.
    task automatic send_str(input string s, input string hits);
        for (int i = 0; i < s.len(); i++) begin
            send(CW'(s[i]), 1'b1, hits[i] == "1");
        end
    endtask

    task automatic set_len(input int n);
        cfg_len_we = 1'b1;
        cfg_len    = LEN_W'(n);
        tick();
        cfg_len_we = 1'b0;
    endtask

    task automatic program_word(input string s);
        for (int i = 0; i < s.len(); i++) begin
            cfg_we   = 1'b1;
            cfg_addr = 3'(i);
            cfg_char = CW'(s[i]);
            tick();
        end
        cfg_we = 1'b0;
        set_len(s.len());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        checks++;
        if (HIT !== 1'b0) begin
            errors++;
            $display("FAIL reset_hit: HIT=%b, expected 0", HIT);
        end
        checks++;
        if (hit_count !== '0) begin
            errors++;
            $display("FAIL reset_count: hit_count=%0d, expected 0", hit_count);
        end
        rst       = 1'b0;
        model_cnt = 0;
    endtask

    initial begin
        rst          = 1'b1;
        letter       = '0;
        letter_valid = 1'b0;
        cfg_we       = 1'b0;
        cfg_addr     = '0;
        cfg_char     = '0;
        cfg_len_we   = 1'b0;
        cfg_len      = '0;
        case_fold    = 1'b0;
        do_reset();

        // COLOR inside a stream containing COLOUR: single hit on the 12th letter.
        program_word("COLOR");
        send_str("ACOLOURCOLORC", "0000000000010");
        do_reset();

        // Overlapping matches.
        program_word("ABAB");
        send_str("ABABAB", "000101");
        do_reset();

        // Case folding applied live, then disabled without flush.
        program_word("COLOR");
        case_fold = 1'b1;
        send_str("cOlOr", "00001");
        case_fold = 1'b0;
        send_str("cOlOr", "00000");
        do_reset();

        // Invalid gap cycles are transparent.
        program_word("CAT");
        send("C", 1'b1, 1'b0);
        repeat (3) send("X", 1'b0, 1'b0);
        send("A", 1'b1, 1'b0);
        send("T", 1'b1, 1'b1);
        do_reset();

        // Length reload flushes partial progress; zero and oversize lengths never hit.
        program_word("CAT");
        send_str("CA", "00");
        set_len(3);
        send_str("T", "0");
        send_str("CAT", "001");
        set_len(0);
        send_str("CATCAT", "000000");
        set_len(MAX_LEN + 5);
        send_str("CATCAT", "000000");
        do_reset();

        // Counter saturation at 2^CNT_W-1, then reset mid-word.
        program_word("AB");
        send_str("ABABABABAB", "0101010101");
        program_word("COLOR");
        send_str("CO", "00");
        do_reset();
        send_str("LOR", "000");

        repeat (4) tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_hits: %0d expected hits never seen, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
